// File: rtl/axi_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_pkg
// Purpose  : Shared state encodings and sizing constants for axi_mem_responder
// Revision : 1.0 - initial release
// ============================================================================
package axi_mem_pkg;

    localparam int MAX_BURST = 16;
    localparam int LAT_W     = 4;
    localparam int BEAT_W    = $clog2(MAX_BURST);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_BURST = 2'd2
    } read_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } write_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_write_address / axi_write_data / axi_write_response /
//            axi_read_address / axi_read_data
// Purpose  : The five AXI-style memory channels, each with master/slave views
// Revision : 1.0 - initial release
// ============================================================================
interface axi_write_address #(parameter int ADDR_WIDTH = 32);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [3:0]            AWLEN;
    logic [3:0]            AWID;
    logic                  AWVALID;
    logic                  AWREADY;
    modport master (output AWADDR, AWLEN, AWID, AWVALID, input AWREADY);
    modport slave  (input AWADDR, AWLEN, AWID, AWVALID, output AWREADY);
endinterface

interface axi_write_data #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WLAST;
    logic [3:0]            WID;
    logic                  WVALID;
    logic                  WREADY;
    modport master (output WDATA, WLAST, WID, WVALID, input WREADY);
    modport slave  (input WDATA, WLAST, WID, WVALID, output WREADY);
endinterface

interface axi_write_response;
    logic [3:0] BID;
    logic       BVALID;
    logic       BREADY;
    modport master (input BID, BVALID, output BREADY);
    modport slave  (output BID, BVALID, input BREADY);
endinterface

interface axi_read_address #(parameter int ADDR_WIDTH = 32);
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [3:0]            ARLEN;
    logic [3:0]            ARID;
    logic                  ARVALID;
    logic                  ARREADY;
    modport master (output ARADDR, ARLEN, ARID, ARVALID, input ARREADY);
    modport slave  (input ARADDR, ARLEN, ARID, ARVALID, output ARREADY);
endinterface

interface axi_read_data #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] RDATA;
    logic                  RLAST;
    logic [3:0]            RID;
    logic                  RVALID;
    logic                  RREADY;
    modport master (input RDATA, RLAST, RID, RVALID, output RREADY);
    modport slave  (output RDATA, RLAST, RID, RVALID, input RREADY);
endinterface
`default_nettype wire

// File: rtl/axi_mem_responder_array.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_array
// Purpose  : 1W/1R word array with a registered, write-first read port
// Revision : 1.0 - initial release
// ============================================================================
module axi_mem_array #(
    parameter int MEM_DEPTH_LOG2 = 12,
    parameter int DATA_WIDTH     = 32
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      wr_en,
    input  wire logic [MEM_DEPTH_LOG2-1:0] wr_addr,
    input  wire logic [DATA_WIDTH-1:0]     wr_data,
    input  wire logic                      rd_en,
    input  wire logic [MEM_DEPTH_LOG2-1:0] rd_addr,
    output logic      [DATA_WIDTH-1:0]     rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_DEPTH_LOG2)-1];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Storage is deliberately not reset so contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_responder
// Purpose  : AXI-style slave terminating read and write bursts on a word array
// Revision : 1.0 - initial release
// ============================================================================
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int MEM_DEPTH_LOG2 = 12,
    parameter int READ_LATENCY   = 2,
    parameter int DATA_WIDTH     = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    axi_write_address.slave  aw,
    axi_write_data.slave     w,
    axi_write_response.slave b,
    axi_read_address.slave   ar,
    axi_read_data.slave      r,
    output logic             protocol_error
);

    localparam int               C_LAT_M1   = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
    localparam logic [LAT_W-1:0] c_lat_init = LAT_W'(C_LAT_M1);

    read_state_t                rd_state_q, rd_state_d;
    logic [MEM_DEPTH_LOG2-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [BEAT_W-1:0]          rd_len_q,   rd_len_d;
    logic [BEAT_W-1:0]          rd_beat_q,  rd_beat_d;
    logic [3:0]                 rd_id_q,    rd_id_d;
    logic [LAT_W-1:0]           rd_lat_q,   rd_lat_d;

    write_state_t               wr_state_q, wr_state_d;
    logic [MEM_DEPTH_LOG2-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [BEAT_W-1:0]          wr_len_q,   wr_len_d;
    logic [BEAT_W-1:0]          wr_beat_q,  wr_beat_d;
    logic [3:0]                 wr_id_q,    wr_id_d;
    logic                       err_q,      err_d;

    logic                       w_mem_rd_en;
    logic [MEM_DEPTH_LOG2-1:0]  w_mem_rd_addr;
    logic                       w_mem_wr_en;
    logic [DATA_WIDTH-1:0]      w_mem_rd_data;
    logic                       w_unused;

    assign w_unused = ^{aw.AWADDR, ar.ARADDR};

    // The data register is loaded in the cycle before each beat is presented,
    // so RDATA never depends combinationally on RREADY.
    always_comb begin
        rd_state_d    = rd_state_q;
        rd_ptr_d      = rd_ptr_q;
        rd_len_d      = rd_len_q;
        rd_beat_d     = rd_beat_q;
        rd_id_d       = rd_id_q;
        rd_lat_d      = rd_lat_q;
        w_mem_rd_en   = 1'b0;
        w_mem_rd_addr = rd_ptr_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar.ARVALID) begin
                    rd_ptr_d  = ar.ARADDR[MEM_DEPTH_LOG2+1:2];
                    rd_len_d  = ar.ARLEN;
                    rd_id_d   = ar.ARID;
                    rd_beat_d = '0;
                    rd_lat_d  = c_lat_init;
                    if (READ_LATENCY == 0) begin
                        rd_state_d    = R_BURST;
                        w_mem_rd_en   = 1'b1;
                        w_mem_rd_addr = ar.ARADDR[MEM_DEPTH_LOG2+1:2];
                    end else begin
                        rd_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (rd_lat_q == '0) begin
                    rd_state_d  = R_BURST;
                    w_mem_rd_en = 1'b1;
                end else begin
                    rd_lat_d = rd_lat_q - 1'b1;
                end
            end
            R_BURST: begin
                if (r.RREADY) begin
                    if (rd_beat_q == rd_len_q) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        rd_beat_d     = rd_beat_q + 1'b1;
                        rd_ptr_d      = rd_ptr_q + 1'b1;
                        w_mem_rd_en   = 1'b1;
                        w_mem_rd_addr = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Burst end is decided by the beat count; WLAST is only cross-checked.
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_len_d    = wr_len_q;
        wr_beat_d   = wr_beat_q;
        wr_id_d     = wr_id_q;
        err_d       = err_q;
        w_mem_wr_en = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw.AWVALID) begin
                    wr_ptr_d   = aw.AWADDR[MEM_DEPTH_LOG2+1:2];
                    wr_len_d   = aw.AWLEN;
                    wr_id_d    = aw.AWID;
                    wr_beat_d  = '0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w.WVALID) begin
                    w_mem_wr_en = 1'b1;
                    wr_ptr_d    = wr_ptr_q + 1'b1;
                    wr_beat_d   = wr_beat_q + 1'b1;
                    if ((w.WLAST != (wr_beat_q == wr_len_q)) || (w.WID != wr_id_q)) begin
                        err_d = 1'b1;
                    end
                    if (wr_beat_q == wr_len_q) begin
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (b.BREADY) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_ptr_q   <= '0;
            rd_len_q   <= '0;
            rd_beat_q  <= '0;
            rd_id_q    <= '0;
            rd_lat_q   <= '0;
            wr_state_q <= W_IDLE;
            wr_ptr_q   <= '0;
            wr_len_q   <= '0;
            wr_beat_q  <= '0;
            wr_id_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_len_q   <= rd_len_d;
            rd_beat_q  <= rd_beat_d;
            rd_id_q    <= rd_id_d;
            rd_lat_q   <= rd_lat_d;
            wr_state_q <= wr_state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_len_q   <= wr_len_d;
            wr_beat_q  <= wr_beat_d;
            wr_id_q    <= wr_id_d;
            err_q      <= err_d;
        end
    end

    axi_mem_array #(
        .MEM_DEPTH_LOG2 (MEM_DEPTH_LOG2),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_mem_wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (w.WDATA),
        .rd_en   (w_mem_rd_en),
        .rd_addr (w_mem_rd_addr),
        .rd_data (w_mem_rd_data)
    );

    assign ar.ARREADY     = (rd_state_q == R_IDLE);
    assign r.RVALID       = (rd_state_q == R_BURST);
    assign r.RLAST        = (rd_state_q == R_BURST) && (rd_beat_q == rd_len_q);
    assign r.RID          = rd_id_q;
    assign r.RDATA        = w_mem_rd_data;
    assign aw.AWREADY     = (wr_state_q == W_IDLE);
    assign w.WREADY       = (wr_state_q == W_DATA);
    assign b.BVALID       = (wr_state_q == W_RESP);
    assign b.BID          = wr_id_q;
    assign protocol_error = err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axi_mem_responder
// Purpose  : Directed self-checking bench; a 16-word twin shares all stimulus
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic perr0;
    logic perr1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rd_span;
    int wr_span;
    int rd_lat;
    bit chk1     = 1'b0;
    logic [31:0] wr_data [16];
    logic [31:0] exp_rd  [16];
    logic [31:0] exp_rd1 [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_write_address  aw0 ();
    axi_write_data     w0  ();
    axi_write_response b0  ();
    axi_read_address   ar0 ();
    axi_read_data      r0  ();
    axi_write_address  aw1 ();
    axi_write_data     w1  ();
    axi_write_response b1  ();
    axi_read_address   ar1 ();
    axi_read_data      r1  ();

    assign aw1.AWADDR  = aw0.AWADDR;
    assign aw1.AWLEN   = aw0.AWLEN;
    assign aw1.AWID    = aw0.AWID;
    assign aw1.AWVALID = aw0.AWVALID;
    assign w1.WDATA    = w0.WDATA;
    assign w1.WLAST    = w0.WLAST;
    assign w1.WID      = w0.WID;
    assign w1.WVALID   = w0.WVALID;
    assign b1.BREADY   = b0.BREADY;
    assign ar1.ARADDR  = ar0.ARADDR;
    assign ar1.ARLEN   = ar0.ARLEN;
    assign ar1.ARID    = ar0.ARID;
    assign ar1.ARVALID = ar0.ARVALID;
    assign r1.RREADY   = r0.RREADY;

    axi_mem_responder #(.MEM_DEPTH_LOG2(12), .READ_LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .aw(aw0), .w(w0), .b(b0), .ar(ar0), .r(r0),
        .protocol_error(perr0)
    );

    axi_mem_responder #(.MEM_DEPTH_LOG2(4), .READ_LATENCY(2)) u_dut_small (
        .clk(clk), .rst(rst), .aw(aw1), .w(w1), .b(b1), .ar(ar1), .r(r1),
        .protocol_error(perr1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // bad_last < 0 drives a correct WLAST; otherwise WLAST is high only on that beat.
    task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                             input int bad_last, input logic [3:0] wid);
        int n;
        int t;
        int ln;
        ln = int'(len);
        aw0.AWADDR  = addr;
        aw0.AWLEN   = len;
        aw0.AWID    = id;
        aw0.AWVALID = 1'b1;
        n = 0;
        while (!aw0.AWREADY && n < 64) begin step(); n++; end
        check("awready", aw0.AWREADY, 1);
        t = cyc;
        step();
        aw0.AWVALID = 1'b0;
        check("wready_after_aw", w0.WREADY, 1);
        for (int i = 0; i <= ln; i++) begin
            w0.WVALID = 1'b1;
            w0.WDATA  = wr_data[i];
            w0.WLAST  = (bad_last < 0) ? (i == ln) : (i == bad_last);
            w0.WID    = wid;
            n = 0;
            while (!w0.WREADY && n < 64) begin step(); n++; end
            check("wready", w0.WREADY, 1);
            step();
        end
        w0.WVALID = 1'b0;
        w0.WLAST  = 1'b0;
        check("bvalid_after_last", b0.BVALID, 1);
        check("wready_after_last", w0.WREADY, 0);
        b0.BREADY = 1'b1;
        check("bid", b0.BID, id);
        step();
        b0.BREADY = 1'b0;
        check("awready_after_b", aw0.AWREADY, 1);
        wr_span = cyc - t;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                            input bit stall);
        int n;
        int t;
        int ln;
        ln = int'(len);
        ar0.ARADDR  = addr;
        ar0.ARLEN   = len;
        ar0.ARID    = id;
        ar0.ARVALID = 1'b1;
        n = 0;
        while (!ar0.ARREADY && n < 64) begin step(); n++; end
        check("arready", ar0.ARREADY, 1);
        t = cyc;
        step();
        ar0.ARVALID = 1'b0;
        check("arready_busy", ar0.ARREADY, 0);
        n = 0;
        while (!r0.RVALID && n < 64) begin step(); n++; end
        rd_lat = n;
        for (int i = 0; i <= ln; i++) begin
            check("rvalid", r0.RVALID, 1);
            check("rdata", r0.RDATA, exp_rd[i]);
            check("rlast", r0.RLAST, (i == ln));
            check("rid", r0.RID, id);
            if (chk1) check("rdata_small", r1.RDATA, exp_rd1[i]);
            if (stall) begin
                r0.RREADY = 1'b0;
                step();
                check("rdata_hold", r0.RDATA, exp_rd[i]);
                check("rlast_hold", r0.RLAST, (i == ln));
            end
            r0.RREADY = 1'b1;
            step();
        end
        r0.RREADY = 1'b0;
        check("arready_done", ar0.ARREADY, 1);
        rd_span = cyc - t;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time observed 200000ns, required completion earlier");
        $fatal(1);
    end

    initial begin
        int n;
        aw0.AWADDR = '0; aw0.AWLEN = '0; aw0.AWID = '0; aw0.AWVALID = 1'b0;
        w0.WDATA = '0; w0.WLAST = 1'b0; w0.WID = '0; w0.WVALID = 1'b0;
        b0.BREADY = 1'b0;
        ar0.ARADDR = '0; ar0.ARLEN = '0; ar0.ARID = '0; ar0.ARVALID = 1'b0;
        r0.RREADY = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", ar0.ARREADY, 1);
        check("rst_awready", aw0.AWREADY, 1);
        check("rst_rvalid", r0.RVALID, 0);
        check("rst_rlast", r0.RLAST, 0);
        check("rst_wready", w0.WREADY, 0);
        check("rst_bvalid", b0.BVALID, 0);
        check("rst_rid", r0.RID, 0);
        check("rst_bid", b0.BID, 0);
        check("rst_rdata", r0.RDATA, 0);
        check("rst_perr", perr0, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Single-beat write then read, 3-cycle read turnaround
        wr_data[0] = 32'hDEADBEEF;
        axi_write(32'h100, 4'd0, 4'd3, -1, 4'd3);
        exp_rd[0] = 32'hDEADBEEF;
        axi_read(32'h100, 4'd0, 4'd5, 1'b0);
        check("rd_latency", rd_lat, 2);

        // Words 0..31 hold their own index
        for (int i = 0; i < 16; i++) wr_data[i] = i;
        axi_write(32'h0, 4'd15, 4'd1, -1, 4'd1);
        for (int i = 0; i < 16; i++) wr_data[i] = 16 + i;
        axi_write(32'h40, 4'd15, 4'd2, -1, 4'd2);

        // 16-beat read with RREADY toggling
        for (int i = 0; i < 16; i++) exp_rd[i] = 16 + i;
        axi_read(32'h40, 4'd15, 4'd7, 1'b1);

        // Wrap: the 16-word twin lands beats on words 14,15,0,1
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hA5A5_0000 + i;
        axi_write(32'h38, 4'd3, 4'd4, -1, 4'd4);
        chk1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_rd[i]  = 32'hA5A5_0000 + i;
            exp_rd1[i] = 32'hA5A5_0000 + i;
        end
        axi_read(32'h38, 4'd3, 4'd6, 1'b0);
        exp_rd[0]  = 32'd0;
        exp_rd[1]  = 32'd1;
        exp_rd1[0] = 32'hA5A5_0002;
        exp_rd1[1] = 32'hA5A5_0003;
        axi_read(32'h0, 4'd1, 4'd6, 1'b0);
        chk1 = 1'b0;

        // Concurrent 4-beat write (words 0..3) and read (words 8..11)
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = 32'hC0DE_0000 + i;
            exp_rd[i]  = 8 + i;
        end
        fork
            axi_write(32'h0, 4'd3, 4'd9, -1, 4'd9);
            axi_read(32'h20, 4'd3, 4'd10, 1'b0);
        join
        check("conc_rd_span", rd_span, 7);
        check("conc_wr_span", wr_span, 6);

        // Write to word 9 lands in the cycle word 9 is prefetched
        wr_data[0] = 32'h9999_0009;
        exp_rd[0]  = 32'd8;
        exp_rd[1]  = 32'h9999_0009;
        fork
            axi_read(32'h20, 4'd1, 4'd11, 1'b0);
            begin
                step();
                step();
                axi_write(32'h24, 4'd0, 4'd12, -1, 4'd12);
            end
        join

        // Early WLAST flags an error but the burst still runs 4 beats
        check("perr_clean", perr0, 0);
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hE000_0000 + i;
        axi_write(32'h80, 4'd3, 4'd1, 2, 4'd1);
        check("perr_wlast", perr0, 1);
        for (int i = 0; i < 4; i++) exp_rd[i] = 32'hE000_0000 + i;
        axi_read(32'h80, 4'd3, 4'd2, 1'b0);

        // Reset asserted mid-read
        ar0.ARADDR = 32'h80; ar0.ARLEN = 4'd3; ar0.ARID = 4'hA; ar0.ARVALID = 1'b1;
        step();
        ar0.ARVALID = 1'b0;
        n = 0;
        while (!r0.RVALID && n < 64) begin step(); n++; end
        r0.RREADY = 1'b1;
        step();
        r0.RREADY = 1'b0;
        check("mid_rvalid", r0.RVALID, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rvalid", r0.RVALID, 0);
        check("mid_rst_arready", ar0.ARREADY, 1);
        check("mid_rst_perr", perr0, 0);
        check("mid_rst_rdata", r0.RDATA, 0);
        check("mid_rst_rid", r0.RID, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Contents survive reset; WID mismatch sets the error again
        axi_read(32'h80, 4'd3, 4'd3, 1'b0);
        wr_data[0] = 32'h0000_5A5A;
        axi_write(32'hC0, 4'd0, 4'd5, -1, 4'd6);
        check("perr_wid", perr0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_mem_responder.md
# axi_mem_responder

Slave-side AXI-style responder that terminates all five DRAM memory channels (write address, write data, write response, read address, read data) against an on-chip word array. It stands in for DRAM in simulation and on FPGA builds, serving the cache-refill and write-back bursts issued by the core's memory masters. Read and write paths are independent, and each has exactly one transaction in flight.

## Interface
- `MEM_DEPTH_LOG2`, default 12: log2 of the number of 32-bit words in the array.
- `READ_LATENCY`, default 2: idle cycles between read-address acceptance and the first `RVALID`; legal range 0..15.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `aw` modport `axi_write_address.slave`: `AWADDR` is `ADDR_WIDTH` (byte address); `AWLEN` is 4 bits (beats-1); `AWID` is 4 bits.
- `w` modport `axi_write_data.slave`: `WDATA` is `DATA_WIDTH`; also `WLAST` and 4-bit `WID`.
- `b` modport `axi_write_response.slave`: `BID` is 4 bits.
- `ar` modport `axi_read_address.slave`: `ARADDR` is `ADDR_WIDTH`; `ARLEN` and `ARID` are 4 bits each.
- `r` modport `axi_read_data.slave`: `RDATA` is `DATA_WIDTH`; also `RLAST` and 4-bit `RID`.
- `protocol_error` output, 1 bit: sticky flag, cleared only by reset.

## Operation
- **Addressing**
  - Word index = `ADDR[MEM_DEPTH_LOG2+1:2]`; `ADDR[1:0]` is ignored.
  - Burst length = `LEN+1` beats (1..16), incrementing by one word per beat.
  - Index wraps modulo 2^`MEM_DEPTH_LOG2`.
- **Read FSM states: R_IDLE, R_WAIT, R_BURST**
  - R_IDLE: `ARREADY`=1. On `ARVALID`, latch address, `ARLEN` and `ARID`, load the latency counter, then go to R_WAIT. When `READ_LATENCY`=0, go directly to R_BURST.
  - R_WAIT: count down, then go to R_BURST.
  - R_BURST: `RVALID`=1, `RID` = latched ID, `RLAST`=1 on beat `LEN` only. `RDATA` comes from an output register.
  - `RDATA`, `RLAST` and `RID` stay stable while `RREADY`=0.
  - On `RVALID&RREADY`: advance the beat counter and pointer, and prefetch the next word into the register. On the last beat, return to R_IDLE.
- **Write FSM states: W_IDLE, W_DATA, W_RESP**
  - W_IDLE: `AWREADY`=1. On `AWVALID`, latch address, `AWLEN` and `AWID`, then go to W_DATA.
  - W_DATA: `WREADY`=1. Each `WVALID&WREADY` writes `WDATA` to the current word and advances. After beat `LEN` is accepted, go to W_RESP.
  - W_RESP: `BVALID`=1, `BID` = latched `AWID`. On `BREADY`, return to W_IDLE.
- **Error conditions.** The beat count alone ends a write burst; `WLAST` does not. `protocol_error` is set when either of these holds on an accepted W beat:
  - `WLAST` does not match (beat == `LEN`);
  - `WID` ≠ latched `AWID`.
- **Collisions.** A write and a read-register load to the same word in the same cycle are write-first: the register captures the new `WDATA`.
- **Reset**
  - Reset may assert mid-burst. It forces both FSMs to idle and abandons any partial burst.
  - Array contents are not cleared.
  - Reset values: `ARREADY`=1, `AWREADY`=1, `RVALID`=0, `RLAST`=0, `WREADY`=0, `BVALID`=0, `RID`=0, `BID`=0, `RDATA`=0, `protocol_error`=0.

## Timing
- **Read**
  - AR handshake in cycle t → first `RVALID` in cycle t+1+`READ_LATENCY`.
  - With `RREADY` held high, one beat per cycle.
  - `ARREADY` is 0 from t+1 until the cycle after the last R beat is accepted.
- **Write**
  - AW handshake in cycle t → `WREADY` in cycle t+1.
  - Last W beat accepted in cycle u → `BVALID` in cycle u+1, `WREADY`=0 in cycle u+1.
  - B handshake in cycle v → `AWREADY`=1 in cycle v+1.
- **Concurrency.** Read and write channels proceed concurrently with no mutual stall.
- **Register timing.** All outputs are registered or decoded from state; there is no combinational path from any input to any output.

## Structure
- Package `axi_mem_pkg` contains:
  - `read_state_t` and `write_state_t` enums;
  - `MAX_BURST` = 16;
  - `LAT_W` = 4.
- Sub-module `axi_mem_array`: 1-write/1-read synchronous word array with write-first bypass, parameterised by `MEM_DEPTH_LOG2`.
- The top level holds both FSMs, the counters, the ID latches and error detection.

## Test plan
- **Single-beat write then read.** AW addr 0x100, LEN 0, ID 3; W 0xDEADBEEF with `WLAST`=1 → `BVALID` with `BID`=3. Then AR addr 0x100, LEN 0, ID 5 → `RDATA`=0xDEADBEEF, `RLAST`=1, `RID`=5, arriving 3 cycles after the AR handshake.
- **16-beat read with stalls.** Array is pre-filled with index values. AR 0x40, LEN 15, and `RREADY` toggled every other cycle → data 0x10..0x1F in order, stable during stalls, `RLAST` only on the 16th beat.
- **Wrap-around.** With `MEM_DEPTH_LOG2`=4, write 4 beats at word 14 → words 14, 15, 0, 1 are written. A read-back returns the same sequence.
- **Concurrent read and write.** A 4-beat write to words 0..3 and a 4-beat read of words 8..11 start in the same cycle → both complete with no added stall.
- **Collision.** Write to word 9 in the same cycle its value is prefetched for the next R beat → that beat returns the new data.
- **Protocol errors and reset.** `WLAST`=1 on beat 2 of LEN 3 → `protocol_error`=1 and the burst continues to 4 beats. Then assert `rst` mid-read → `RVALID`=0 and `ARREADY`=1 immediately, and `protocol_error`=0.
